ysyx_22041071_ifu: RTL and testbench

Instruction fetch unit for the ysyx_22041071 five-stage RV64 core. It owns the architectural fetch PC and issues one instruction-memory request at a time over a valid/ready request channel. It registers each returned instruction into the IF/ID slot and presents it to the decode stage through the PC2/Ins1/valid2/ready2 handshake. It also applies redirects from decode (jal) and execute (branch/jalr), discarding wrong-path fetches.

---
 rtl/ysyx_22041071_ifu_if.sv | 25 ++
 rtl/ysyx_22041071_ifu.sv | 108 ++++++++++
 tb/tb_ysyx_22041071_ifu.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041071_ifu_if.sv
// Instruction-memory channel between the fetch unit (master) and memory (slave).
// One request at a time: valid/ready request with address, response with no back-pressure.
interface ysyx_22041071_ifu_if;
    logic        inst_req_valid;
    logic        inst_req_ready;
    logic [63:0] inst_req_addr;
    logic        inst_rsp_valid;
    logic [31:0] inst_rsp_data;

    modport master (
        output inst_req_valid,
        output inst_req_addr,
        input  inst_req_ready,
        input  inst_rsp_valid,
        input  inst_rsp_data
    );

    modport slave (
        input  inst_req_valid,
        input  inst_req_addr,
        output inst_req_ready,
        output inst_rsp_valid,
        output inst_rsp_data
    );
endinterface

// File: rtl/ysyx_22041071_ifu.sv
// Fetch unit: owns the fetch PC, keeps one memory request in flight, fills the IF/ID slot
// and squashes wrong-path fetches when decode (jal) or execute (branch/jalr) redirects.
module ysyx_22041071_ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    ysyx_22041071_ifu_if.master        imem,
    input  logic                       jump_valid,
    input  logic [63:0]                jump_pc,
    input  logic                       br_valid,
    input  logic [63:0]                br_pc,
    output logic                       valid2,
    output logic [63:0]                PC2,
    output logic [31:0]                Ins1,
    input  logic                       ready2
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0]  state;
    logic [63:0] pc;
    logic [63:0] fetch_pc;
    logic        drop;

    logic        redirect;
    logic [63:0] redirect_pc;
    logic        req_fire;
    logic        rsp_take;
    logic        fill;

    function automatic logic [63:0] align_pc(input logic [63:0] addr);
        return addr & ~64'h3;
    endfunction

    // Execute redirects are older than decode redirects, so they win.
    assign redirect    = br_valid | jump_valid;
    assign redirect_pc = align_pc(br_valid ? br_pc : jump_pc);

    // Only ask for a new word when the slot is guaranteed free before it can return.
    assign imem.inst_req_valid = (state == REQ) & (~valid2 | ready2);
    assign imem.inst_req_addr  = pc;

    assign req_fire = imem.inst_req_valid & imem.inst_req_ready;
    assign rsp_take = (state == WAIT) & imem.inst_rsp_valid;
    assign fill     = rsp_take & ~drop & ~redirect;

    // fetch control: FSM, pc, in-flight address and the squash flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            fetch_pc <= 64'd0;
            drop     <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (req_fire) begin
                        state    <= WAIT;
                        fetch_pc <= pc;
                    end
                end
                WAIT: begin
                    if (imem.inst_rsp_valid) state <= REQ;
                end
                default: state <= IDLE;
            endcase

            // A redirect while a word is in flight squashes that word when it lands.
            if (req_fire)
                drop <= redirect;
            else if (rsp_take)
                drop <= 1'b0;
            else if ((state == WAIT) && redirect)
                drop <= 1'b1;

            if (redirect)
                pc <= redirect_pc;
            else if (fill)
                pc <= fetch_pc + 64'd4;
        end
    end

    // IF/ID slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid2 <= 1'b0;
            PC2    <= 64'd0;
            Ins1   <= 32'd0;
        end else begin
            if (redirect)
                valid2 <= 1'b0;
            else if (fill)
                valid2 <= 1'b1;
            else if (ready2)
                valid2 <= 1'b0;

            if (fill) begin
                PC2  <= fetch_pc;
                Ins1 <= imem.inst_rsp_data;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22041071_ifu.sv
// Bench for the fetch unit: a behavioural instruction memory with variable latency,
// directed scenarios and a randomized run against an in-order delivery model.
module tb_ysyx_22041071_ifu;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        clk;
    logic        reset;
    logic        jump_valid;
    logic [63:0] jump_pc;
    logic        br_valid;
    logic [63:0] br_pc;
    logic        valid2;
    logic [63:0] PC2;
    logic [31:0] Ins1;
    logic        ready2;

    ysyx_22041071_ifu_if mif ();

    ysyx_22041071_ifu #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem       (mif.master),
        .jump_valid (jump_valid),
        .jump_pc    (jump_pc),
        .br_valid   (br_valid),
        .br_pc      (br_pc),
        .valid2     (valid2),
        .PC2        (PC2),
        .Ins1       (Ins1),
        .ready2     (ready2)
    );

    int n_vec = 0;
    int n_err = 0;

    // memory model state
    bit          mem_pending;
    int          mem_cnt;
    logic [63:0] mem_addr;
    int          mem_k;
    bit          mem_krand;

    // per-cycle samples
    logic        s_rv, s_hs, s_pend, s_v2;
    logic [63:0] s_addr, s_pc2;
    logic [31:0] s_ins;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] memword(input logic [63:0] a);
        return a[31:0] ^ {a[15:0], a[31:16]} ^ 32'h1357_9bdf ^ a[63:32];
    endfunction

    task automatic clear_redirect();
        jump_valid = 1'b0;
        jump_pc    = 64'd0;
        br_valid   = 1'b0;
        br_pc      = 64'd0;
    endtask

    // One clock: drive memory response, sample outputs before the edge, advance memory.
    task automatic tick();
        mif.inst_rsp_valid = mem_pending && (mem_cnt == 0);
        mif.inst_rsp_data  = mif.inst_rsp_valid ? memword(mem_addr) : $urandom;
        #1;
        s_rv   = mif.inst_req_valid;
        s_addr = mif.inst_req_addr;
        s_hs   = mif.inst_req_valid && mif.inst_req_ready;
        s_pend = mem_pending;
        s_v2   = valid2;
        s_pc2  = PC2;
        s_ins  = Ins1;
        @(posedge clk);
        if (mif.inst_rsp_valid) mem_pending = 1'b0;
        else if (mem_pending && mem_cnt > 0) mem_cnt--;
        if (s_hs) begin
            mem_pending = 1'b1;
            mem_addr    = s_addr;
            mem_cnt     = (mem_krand ? $urandom_range(1, 3) : mem_k) - 1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_redirect();
        ready2 = 1'b1;
        mif.inst_req_ready = 1'b1;
        mem_pending = 1'b0;
        mem_cnt = 0;
        mem_krand = 1'b0;
        mem_k = 1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_delivery(input int budget, output bit got, output bit req_seen,
                                 output logic [63:0] req_addr);
        got = 1'b0;
        req_seen = 1'b0;
        req_addr = '0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (s_hs && !req_seen) begin
                req_seen = 1'b1;
                req_addr = s_addr;
            end
            if (s_v2) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_redirect();
        ready2 = 1'b0;
        mif.inst_req_ready = 1'b1;
        mem_pending = 1'b0;
        tick();
        tick();
        n_vec++; if (s_v2 !== 1'b0) begin n_err++; $display("FAIL reset_valid2: got %b expected 0", s_v2); end
        n_vec++; if (s_pc2 !== 64'd0) begin n_err++; $display("FAIL reset_pc2: got %h expected 0", s_pc2); end
        n_vec++; if (s_ins !== 32'd0) begin n_err++; $display("FAIL reset_ins1: got %h expected 0", s_ins); end
        n_vec++; if (s_rv !== 1'b0) begin n_err++; $display("FAIL reset_req_valid: got %b expected 0", s_rv); end
        n_vec++; if (s_addr !== RESET_PC) begin n_err++; $display("FAIL reset_req_addr: got %h expected %h", s_addr, RESET_PC); end
    endtask

    task automatic test_first_fetch();
        do_reset();
        tick();
        n_vec++; if (s_rv !== 1'b0) begin n_err++; $display("FAIL first_idle_req: got %b expected 0", s_rv); end
        tick();
        n_vec++; if (s_rv !== 1'b1 || s_addr !== RESET_PC) begin
            n_err++; $display("FAIL first_req: valid %b addr %h expected 1 %h", s_rv, s_addr, RESET_PC); end
        tick();
        n_vec++; if (s_v2 !== 1'b0) begin n_err++; $display("FAIL first_early_valid: got %b expected 0", s_v2); end
        tick();
        n_vec++; if (s_v2 !== 1'b1 || s_pc2 !== RESET_PC || s_ins !== memword(RESET_PC)) begin
            n_err++; $display("FAIL first_deliver: v %b pc %h ins %h expected 1 %h %h", s_v2, s_pc2, s_ins, RESET_PC, memword(RESET_PC)); end
        n_vec++; if (s_rv !== 1'b1 || s_addr !== RESET_PC + 64'd4) begin
            n_err++; $display("FAIL first_next_req: valid %b addr %h expected 1 %h", s_rv, s_addr, RESET_PC + 64'd4); end
    endtask

    task automatic test_stall();
        logic [63:0] rec_pc;
        logic [31:0] rec_ins;
        do_reset();
        tick();
        tick();
        tick();
        ready2 = 1'b0;
        tick();
        rec_pc = s_pc2;
        rec_ins = s_ins;
        n_vec++; if (s_v2 !== 1'b1 || s_pc2 !== RESET_PC || s_rv !== 1'b0) begin
            n_err++; $display("FAIL stall_fill: v %b pc %h req %b expected 1 %h 0", s_v2, s_pc2, s_rv, RESET_PC); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++; if (s_rv !== 1'b0 || s_v2 !== 1'b1 || s_pc2 !== rec_pc || s_ins !== rec_ins) begin
                n_err++; $display("FAIL stall_hold: req %b v %b pc %h ins %h expected 0 1 %h %h", s_rv, s_v2, s_pc2, s_ins, rec_pc, rec_ins); end
        end
        ready2 = 1'b1;
        tick();
        n_vec++; if (s_rv !== 1'b1 || s_addr !== RESET_PC + 64'd4) begin
            n_err++; $display("FAIL stall_release_req: valid %b addr %h expected 1 %h", s_rv, s_addr, RESET_PC + 64'd4); end
    endtask

    task automatic test_branch_in_wait();
        bit got, rs;
        logic [63:0] ra;
        do_reset();
        mem_k = 3;
        tick();
        tick();
        mem_k = 1;
        br_valid = 1'b1;
        br_pc = 64'h0000_0000_8000_1002;
        tick();
        clear_redirect();
        wait_delivery(20, got, rs, ra);
        n_vec++; if (!rs || ra !== 64'h0000_0000_8000_1000) begin
            n_err++; $display("FAIL branch_req_addr: seen %b addr %h expected 80001000", rs, ra); end
        n_vec++; if (!got || s_pc2 !== 64'h0000_0000_8000_1000 || s_ins !== memword(64'h0000_0000_8000_1000)) begin
            n_err++; $display("FAIL branch_deliver: got %b pc %h ins %h expected 80001000", got, s_pc2, s_ins); end
    endtask

    task automatic test_priority();
        bit got, rs;
        logic [63:0] ra;
        do_reset();
        tick();
        jump_valid = 1'b1;
        jump_pc = 64'h0000_0000_8000_0100;
        br_valid = 1'b1;
        br_pc = 64'h0000_0000_8000_0200;
        tick();
        clear_redirect();
        wait_delivery(20, got, rs, ra);
        n_vec++; if (!rs || ra !== 64'h0000_0000_8000_0200) begin
            n_err++; $display("FAIL priority_req_addr: seen %b addr %h expected 80000200", rs, ra); end
        n_vec++; if (!got || s_pc2 !== 64'h0000_0000_8000_0200) begin
            n_err++; $display("FAIL priority_deliver: got %b pc %h expected 80000200", got, s_pc2); end
    endtask

    task automatic test_redirect_with_rsp();
        bit got, rs;
        logic [63:0] ra;
        do_reset();
        mem_k = 2;
        tick();
        tick();
        mem_k = 1;
        tick();
        jump_valid = 1'b1;
        jump_pc = 64'h0000_0000_8000_0400;
        tick();
        clear_redirect();
        wait_delivery(20, got, rs, ra);
        n_vec++; if (!got || s_pc2 !== 64'h0000_0000_8000_0400 || s_ins !== memword(64'h0000_0000_8000_0400)) begin
            n_err++; $display("FAIL rsp_redirect_deliver: got %b pc %h ins %h expected 80000400", got, s_pc2, s_ins); end
    endtask

    task automatic test_redirect_with_req();
        bit got, rs;
        logic [63:0] ra;
        do_reset();
        tick();
        jump_valid = 1'b1;
        jump_pc = 64'h0000_0000_8000_0803;
        tick();
        clear_redirect();
        wait_delivery(20, got, rs, ra);
        n_vec++; if (!got || s_pc2 !== 64'h0000_0000_8000_0800 || s_ins !== memword(64'h0000_0000_8000_0800)) begin
            n_err++; $display("FAIL req_redirect_deliver: got %b pc %h ins %h expected 80000800", got, s_pc2, s_ins); end
    endtask

    task automatic test_wrap();
        bit got, rs;
        logic [63:0] ra;
        do_reset();
        tick();
        br_valid = 1'b1;
        br_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        clear_redirect();
        wait_delivery(20, got, rs, ra);
        n_vec++; if (!got || s_pc2 !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            n_err++; $display("FAIL wrap_deliver: got %b pc %h expected fffffffffffffffc", got, s_pc2); end
        n_vec++; if (s_rv !== 1'b1 || s_addr !== 64'd0) begin
            n_err++; $display("FAIL wrap_next_addr: valid %b addr %h expected 1 0", s_rv, s_addr); end
        wait_delivery(20, got, rs, ra);
        n_vec++; if (!got || s_pc2 !== 64'd0 || s_ins !== memword(64'd0)) begin
            n_err++; $display("FAIL wrap_zero_deliver: got %b pc %h ins %h expected 0 %h", got, s_pc2, s_ins, memword(64'd0)); end
    endtask

    task automatic test_reset_midfetch();
        bit got, rs;
        logic [63:0] ra;
        do_reset();
        tick();
        tick();
        mem_k = 3;
        tick();
        tick();
        n_vec++; if (s_v2 !== 1'b1 || s_hs !== 1'b1) begin
            n_err++; $display("FAIL midreset_setup: v %b hs %b expected 1 1", s_v2, s_hs); end
        mem_k = 1;
        reset = 1'b1;
        #1;
        n_vec++; if (valid2 !== 1'b0 || PC2 !== 64'd0 || Ins1 !== 32'd0 || mif.inst_req_valid !== 1'b0
                     || mif.inst_req_addr !== RESET_PC) begin
            n_err++; $display("FAIL midreset_async: v %b pc %h ins %h req %b addr %h expected 0 0 0 0 %h",
                              valid2, PC2, Ins1, mif.inst_req_valid, mif.inst_req_addr, RESET_PC); end
        tick();
        tick();
        reset = 1'b0;
        wait_delivery(20, got, rs, ra);
        n_vec++; if (!rs || ra !== RESET_PC || !got || s_pc2 !== RESET_PC || s_ins !== memword(RESET_PC)) begin
            n_err++; $display("FAIL midreset_refetch: req %b %h got %b pc %h ins %h expected %h", rs, ra, got, s_pc2, s_ins, RESET_PC); end
    endtask

    task automatic test_random();
        logic [63:0] exp_pc, hold_pc;
        logic [31:0] hold_ins;
        bit hold, redir;
        int deliveries;
        do_reset();
        mem_krand = 1'b1;
        exp_pc = RESET_PC;
        hold = 1'b0;
        hold_pc = '0;
        hold_ins = '0;
        deliveries = 0;
        for (int c = 0; c < 4000; c++) begin
            ready2 = ($urandom_range(0, 9) < 7);
            mif.inst_req_ready = ($urandom_range(0, 9) < 7);
            br_valid = ($urandom_range(0, 39) == 0);
            jump_valid = ($urandom_range(0, 29) == 0);
            br_pc = 64'h0000_0000_8000_0000 + 64'($urandom_range(0, 65535));
            jump_pc = 64'h0000_0000_8000_0000 + 64'($urandom_range(0, 65535));
            redir = br_valid || jump_valid;
            tick();
            if (hold) begin
                n_vec++; if (s_v2 !== 1'b1 || s_pc2 !== hold_pc || s_ins !== hold_ins) begin
                    n_err++; $display("FAIL rand_hold c%0d: v %b pc %h ins %h expected 1 %h %h", c, s_v2, s_pc2, s_ins, hold_pc, hold_ins); end
            end
            if (s_v2) begin
                n_vec++; if (s_pc2 !== exp_pc || s_ins !== memword(exp_pc)) begin
                    n_err++; $display("FAIL rand_deliver c%0d: pc %h ins %h expected %h %h", c, s_pc2, s_ins, exp_pc, memword(exp_pc)); end
            end
            if (s_pend) begin
                n_vec++; if (s_rv !== 1'b0) begin
                    n_err++; $display("FAIL rand_outstanding c%0d: req_valid %b expected 0 while waiting", c, s_rv); end
            end
            if (s_v2 && ready2) begin
                exp_pc = exp_pc + 64'd4;
                deliveries++;
            end
            if (redir) exp_pc = (br_valid ? br_pc : jump_pc) & ~64'h3;
            hold = s_v2 && !ready2 && !redir;
            hold_pc = s_pc2;
            hold_ins = s_ins;
        end
        clear_redirect();
        mem_krand = 1'b0;
        n_vec++; if (deliveries < 200) begin
            n_err++; $display("FAIL rand_progress: got %0d deliveries expected at least 200", deliveries); end
    endtask

    initial begin
        reset = 1'b1;
        clear_redirect();
        ready2 = 1'b0;
        mif.inst_req_ready = 1'b1;
        mif.inst_rsp_valid = 1'b0;
        mif.inst_rsp_data = 32'd0;
        mem_pending = 1'b0;
        mem_cnt = 0;
        mem_addr = '0;
        mem_k = 1;
        mem_krand = 1'b0;

        test_reset();
        test_first_fetch();
        test_stall();
        test_branch_in_wait();
        test_priority();
        test_redirect_with_rsp();
        test_redirect_with_req();
        test_wrap();
        test_reset_midfetch();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
